// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel FIFO: RGB565 field layout, FSM states
// and the default underrun colour.
package lcd_pkg;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;

    // Magenta stands out on a panel, so underruns are easy to spot.
    localparam logic [PIX_W-1:0] FILL_COLOR_DEF = 16'hF81F;

    typedef enum logic [2:0] {
        SYNC,
        FILL,
        WAIT_VS,
        RUN,
        ERR
    } lcd_state_e;

endpackage

// File: rtl/lcd_pixel_fifo_if.sv
// Upstream pixel stream into the LCD FIFO: valid/ready handshake carrying an
// RGB565 word and a start-of-frame marker.
interface lcd_pixel_fifo_if;
    import lcd_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             s_sof;

    modport master (output s_valid, output s_data, output s_sof, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_sof, output s_ready);

endinterface

// File: rtl/lcd_pix_ram.sv
// Pixel storage: simple dual-port RAM, synchronous write, asynchronous read.
// Contents are deliberately left unreset so it maps onto distributed RAM.
module lcd_pix_ram
    import lcd_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             PixelClk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge PixelClk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_pixel_fifo.sv
// First-word-fall-through pixel FIFO between a pixel source and an LCD timing
// generator. Define LCD_PIX_FIFO_FILL_EN to emit FILL_COLOR on underrun
// instead of repeating the last popped pixel.
module lcd_pixel_fifo
    import lcd_pkg::*;
#(
    parameter int               DEPTH      = 1024,
    parameter int               PREFILL    = 512,
    parameter logic [PIX_W-1:0] FILL_COLOR = FILL_COLOR_DEF,
    localparam int              AW         = $clog2(DEPTH),
    localparam int              LW         = AW + 1
) (
    input  logic            PixelClk,
    input  logic            nRST,
    lcd_pixel_fifo_if.slave s,
    input  logic            de_i,
    input  logic            vsync_i,
    input  logic            clr_err,
    output logic [R_W-1:0]  LCD_R,
    output logic [G_W-1:0]  LCD_G,
    output logic [B_W-1:0]  LCD_B,
    output logic [LW-1:0]   level,
    output logic            underrun
);

    lcd_state_e       state_q, state_d;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    level_q;
    logic             vs_q;
    logic             rdy_en_q;
    logic             underrun_q;
    logic [PIX_W-1:0] last_pix_q;

    logic             empty, full, vs_fall;
    logic             ready, push, pop, flush, err_set;
    logic [PIX_W-1:0] head, upix, pix;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign vs_fall = vs_q & ~vsync_i;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        err_set = 1'b0;
        case (state_q)
            SYNC: begin
                // Hunt for a frame start; everything before it is dropped.
                flush = 1'b1;
                ready = rdy_en_q;
                if (s.s_valid && ready && s.s_sof) begin
                    push    = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                ready = ~full;
                push  = s.s_valid & ready;
                if ((level_q + LW'(push)) >= LW'(PREFILL)) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                ready = ~full;
                push  = s.s_valid & ready;
                if (vs_fall) state_d = RUN;
            end
            RUN: begin
                ready = ~full;
                push  = s.s_valid & ready;
                if (de_i) begin
                    if (empty) begin
                        err_set = 1'b1;
                        state_d = ERR;
                    end else begin
                        pop = 1'b1;
                    end
                end
                // A new frame arriving before the old one drained means the
                // source and panel have slipped relative to each other.
                if (push && s.s_sof && !empty) begin
                    err_set = 1'b1;
                    state_d = ERR;
                end
            end
            ERR: begin
                ready = 1'b1;
                if (vs_fall) state_d = SYNC;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= SYNC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            vs_q       <= 1'b1;
            rdy_en_q   <= 1'b0;
            underrun_q <= 1'b0;
            last_pix_q <= '0;
        end else begin
            state_q  <= state_d;
            vs_q     <= vsync_i;
            rdy_en_q <= 1'b1;
            if (flush) begin
                rptr_q  <= '0;
                wptr_q  <= AW'(push);
                level_q <= LW'(push);
            end else begin
                wptr_q  <= wptr_q + AW'(push);
                rptr_q  <= rptr_q + AW'(pop);
                level_q <= level_q + LW'(push) - LW'(pop);
            end
            if (err_set)      underrun_q <= 1'b1;
            else if (clr_err) underrun_q <= 1'b0;
            if (pop) last_pix_q <= head;
        end
    end

    lcd_pix_ram #(.DEPTH(DEPTH)) u_ram (
        .PixelClk (PixelClk),
        .we       (push),
        .waddr    (flush ? '0 : wptr_q),
        .wdata    (s.s_data),
        .raddr    (rptr_q),
        .rdata    (head)
    );

`ifdef LCD_PIX_FIFO_FILL_EN
    assign upix = FILL_COLOR;
`else
    assign upix = last_pix_q;
`endif

    always_comb begin
        pix = '0;
        if (de_i) begin
            if (state_q == RUN)      pix = empty ? upix : head;
            else if (state_q == ERR) pix = upix;
        end
    end

    assign {LCD_R, LCD_G, LCD_B} = pix;
    assign s.s_ready = ready;
    assign level     = level_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_lcd_pixel_fifo.sv
// Directed bench for lcd_pixel_fifo: scoreboard queue of pushed pixels,
// immediate assertions at every comparison point.
module tb_lcd_pixel_fifo;
    import lcd_pkg::*;

    logic        PixelClk;
    logic        nRST;
    logic        de_i, vsync_i, clr_err;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic [10:0] level;
    logic        underrun;

    lcd_pixel_fifo_if sif ();

    lcd_pixel_fifo dut (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .s        (sif.slave),
        .de_i     (de_i),
        .vsync_i  (vsync_i),
        .clr_err  (clr_err),
        .LCD_R    (LCD_R),
        .LCD_G    (LCD_G),
        .LCD_B    (LCD_B),
        .level    (level),
        .underrun (underrun)
    );

    initial PixelClk = 1'b0;
    always #5 PixelClk = ~PixelClk;

    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last = '0;
    logic [15:0] exp_v;

    function automatic logic [15:0] pix(input int i);
        return 16'(i * 37 + 165);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PixelClk);
        #1;
    endtask

    task automatic push_px(input logic sof);
        sif.s_valid = 1'b1;
        sif.s_sof   = sof;
        sif.s_data  = pix(n);
        exp_q.push_back(pix(n));
        n++;
    endtask

    task automatic idle_src();
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
    endtask

    // One de_i cycle: the head must be on the pins before the edge pops it.
    task automatic de_pop(input string tag);
        de_i = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed pixel with empty scoreboard, expected none", tag);
        end else begin
            exp_v = exp_q.pop_front();
            chk(tag, 32'({LCD_R, LCD_G, LCD_B}), 32'(exp_v));
            last = exp_v;
        end
        tick();
    endtask

    task automatic vs_pulse();
        vsync_i = 1'b0;
        tick();
        vsync_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b1; de_i = 1'b0; vsync_i = 1'b1; clr_err = 1'b0;
        sif.s_valid = 1'b0; sif.s_sof = 1'b0; sif.s_data = '0;
        #1 nRST = 1'b0;
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_ready", 32'(sif.s_ready), 0);
        chk("rst_lcd", 32'({LCD_R, LCD_G, LCD_B}), 0);
        chk("rst_state", 32'(dut.state_q), 32'(SYNC));
        tick(); tick();
        nRST = 1'b1;
        chk("ready_low_at_release", 32'(sif.s_ready), 0);
        tick();
        chk("ready_after_release", 32'(sif.s_ready), 1);

        // Pixels without a frame start are discarded.
        for (int i = 0; i < 10; i++) begin
            sif.s_valid = 1'b1; sif.s_sof = 1'b0; sif.s_data = pix(n); n++;
            tick();
        end
        idle_src();
        chk("nosof_level", 32'(level), 0);
        chk("nosof_state", 32'(dut.state_q), 32'(SYNC));

        // Prefill to 512, keep writing to 600, start on VSYNC falling edge.
        for (int i = 0; i < 600; i++) begin
            push_px(i == 0);
            tick();
            if (i == 0)   chk("fill_state", 32'(dut.state_q), 32'(FILL));
            if (i == 511) begin
                chk("prefill_level", 32'(level), 512);
                chk("prefill_state", 32'(dut.state_q), 32'(WAIT_VS));
            end
        end
        idle_src();
        chk("level600", 32'(level), 600);
        vs_pulse();
        chk("run_state", 32'(dut.state_q), 32'(RUN));

        for (int i = 0; i < 800; i++) begin
            push_px(1'b0);
            de_pop("run_pix");
        end
        idle_src();
        chk("run_level", 32'(level), 600);
        chk("run_no_underrun", 32'(underrun), 0);

        // Drain to 3, then run dry.
        for (int i = 0; i < 597; i++) de_pop("drain_pix");
        chk("level3", 32'(level), 3);
        for (int i = 0; i < 3; i++) de_pop("last3_pix");
`ifdef LCD_PIX_FIFO_FILL_EN
        exp_v = 16'hF81F;
`else
        exp_v = last;
`endif
        for (int i = 0; i < 2; i++) begin
            de_i = 1'b1;
            #1;
            chk("underrun_pix", 32'({LCD_R, LCD_G, LCD_B}), 32'(exp_v));
            tick();
            chk("underrun_flag", 32'(underrun), 1);
            chk("err_state", 32'(dut.state_q), 32'(ERR));
        end
        de_i = 1'b0;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err", 32'(underrun), 0);
        vs_pulse();
        chk("err_to_sync", 32'(dut.state_q), 32'(SYNC));

        // Fill to full; extra valid is ignored; one pop reopens the FIFO.
        for (int i = 0; i < 1024; i++) begin
            push_px(i == 0);
            tick();
        end
        idle_src();
        chk("full_level", 32'(level), 1024);
        chk("full_ready", 32'(sif.s_ready), 0);
        sif.s_valid = 1'b1; sif.s_data = 16'hDEAD;
        tick();
        idle_src();
        chk("full_ignore", 32'(level), 1024);
        vs_pulse();
        de_pop("full_pop");
        de_i = 1'b0;
        chk("full_pop_ready", 32'(sif.s_ready), 1);
        chk("full_pop_level", 32'(level), 1023);

        // Down to 100, then push+pop together across the read-pointer wrap.
        for (int i = 0; i < 923; i++) de_pop("to100_pix");
        chk("level100", 32'(level), 100);
        for (int i = 0; i < 50; i++) begin
            push_px(1'b0);
            de_pop("pp_pix");
        end
        idle_src();
        chk("pp_level", 32'(level), 100);
        for (int i = 0; i < 150; i++) begin
            push_px(1'b0);
            de_pop("wrap_pix");
        end
        idle_src();
        de_i = 1'b0;
        chk("wrap_level", 32'(level), 100);
        for (int i = 0; i < 200; i++) begin
            push_px(1'b0);
            tick();
        end
        idle_src();
        chk("level300", 32'(level), 300);

        // Asynchronous reset in the middle of RUN.
        nRST = 1'b0;
        #1;
        chk("midrst_level", 32'(level), 0);
        chk("midrst_state", 32'(dut.state_q), 32'(SYNC));
        chk("midrst_ready", 32'(sif.s_ready), 0);
        exp_q.delete();
        tick();
        nRST = 1'b1;
        tick();

        // Underrun and clr_err in the same cycle: set wins.
        for (int i = 0; i < 512; i++) begin
            push_px(i == 0);
            tick();
        end
        idle_src();
        vs_pulse();
        for (int i = 0; i < 512; i++) de_pop("refill_pix");
`ifndef LCD_PIX_FIFO_FILL_EN
        exp_v = last;
`endif
        de_i = 1'b1; clr_err = 1'b1;
        #1;
        chk("setwins_pix", 32'({LCD_R, LCD_G, LCD_B}), 32'(exp_v));
        tick();
        de_i = 1'b0; clr_err = 1'b0;
        chk("setwins_flag", 32'(underrun), 1);

        // Frame slip: a new SOF while data is still queued.
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err2", 32'(underrun), 0);
        vs_pulse();
        for (int i = 0; i < 512; i++) begin
            push_px(i == 0);
            tick();
        end
        idle_src();
        vs_pulse();
        chk("slip_run", 32'(dut.state_q), 32'(RUN));
        push_px(1'b1);
        tick();
        idle_src();
        chk("slip_state", 32'(dut.state_q), 32'(ERR));
        chk("slip_flag", 32'(underrun), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
